// File: rtl/decode_pkg.sv
// Shared definitions for the decode-stage register file and pending-write
// scoreboard: default sizes plus small helpers for pulling one lane out of
// the flattened address/data buses and for counting writeback lanes that
// target a given register.
package decode_pkg;

   localparam int DATA_W = 32;
   localparam int NREG   = 32;
   localparam int AW     = $clog2(NREG);
   localparam int NRD    = 2;
   localparam int NWB    = 2;
   localparam int CNT_W  = 2;
   // Wide enough to hold the number of lanes that hit one register.
   localparam int DEC_W  = $clog2(NWB + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   function automatic logic [AW-1:0] rd_addr_at(input logic [NRD*AW-1:0] v, input int i);
      return v[i*AW +: AW];
   endfunction

   function automatic logic [AW-1:0] wb_addr_at(input logic [NWB*AW-1:0] v, input int l);
      return v[l*AW +: AW];
   endfunction

   function automatic logic [DATA_W-1:0] wb_data_at(input logic [NWB*DATA_W-1:0] v, input int l);
      return v[l*DATA_W +: DATA_W];
   endfunction

   // Number of enabled writeback lanes retiring register r (never r0).
   function automatic logic [DEC_W-1:0] lane_match_cnt(input logic [NWB-1:0]    en,
                                                        input logic [NWB*AW-1:0] addr,
                                                        input logic [AW-1:0]     r);
      logic [DEC_W-1:0] n;
      n = '0;
      for (int l = 0; l < NWB; l++) begin
         if (en[l] && (addr[l*AW +: AW] == r) && (r != '0)) n = n + DEC_W'(1);
      end
      return n;
   endfunction

endpackage

// File: rtl/decode_regfile_scoreboard_if.sv
// Bundle of the decode-stage read, issue and writeback signals.
//   master : issue/writeback source (drives addresses, issue info, writebacks, flush)
//   slave  : register file + scoreboard (returns read data, stall, busy, error)
// Issue handshake: an instruction presented with iss_valid is accepted on the
// rising clock edge only when stall is low in that same cycle; while stall is
// high the source holds the instruction and nothing is recorded.
interface decode_regfile_scoreboard_if;
   import decode_pkg::*;

   logic [NRD*AW-1:0]     rd_addr;
   logic [NRD*DATA_W-1:0] rd_data;
   logic [NRD-1:0]        iss_src_en;
   logic                  iss_valid;
   logic                  iss_dst_en;
   logic [AW-1:0]         iss_dst;
   logic [NWB-1:0]        wb_en;
   logic [NWB*AW-1:0]     wb_addr;
   logic [NWB*DATA_W-1:0] wb_data;
   logic                  flush;
   logic                  stall;
   logic [NREG-1:0]       busy;
   logic                  err_underflow;

   modport master (
      output rd_addr, iss_src_en, iss_valid, iss_dst_en, iss_dst,
             wb_en, wb_addr, wb_data, flush,
      input  rd_data, stall, busy, err_underflow
   );

   modport slave (
      input  rd_addr, iss_src_en, iss_valid, iss_dst_en, iss_dst,
             wb_en, wb_addr, wb_data, flush,
      output rd_data, stall, busy, err_underflow
   );

endinterface

// File: rtl/decode_regfile_scoreboard_sb_counter.sv
// Pending-write counter for one architectural register.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   inc_i         : an accepted issue names this register as destination
//   dec_i         : number of writeback lanes retiring this register
//   clr_i         : flush, drops all pending writes
//   cnt_o         : outstanding writes
//   sat_o         : counter is full, no further issue may target it
//   underflow_o   : this cycle retires more writes than were pending
module sb_counter
   import decode_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic [DEC_W-1:0] dec_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             sat_o,
   output logic             underflow_o
);

   // Arithmetic width that holds both cnt+inc and the largest dec.
   localparam int SW = ((CNT_W + 1) > DEC_W) ? (CNT_W + 1) : DEC_W;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SW-1:0]    sum, dec_w, diff;

   always_comb begin
      sum         = SW'(cnt_q) + SW'(inc_i);
      dec_w       = SW'(dec_i);
      diff        = sum - dec_w;
      underflow_o = 1'b0;
      cnt_d       = cnt_q;
      if (clr_i) begin
         // Flush wins over everything and never flags an underflow.
         cnt_d = '0;
      end else if (dec_w > sum) begin
         cnt_d       = '0;
         underflow_o = 1'b1;
      end else if (diff > SW'(CNT_MAX)) begin
         cnt_d = CNT_MAX;
      end else begin
         cnt_d = diff[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
   assign sat_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/decode_regfile_scoreboard.sv
// Decode-stage register file with same-cycle writeback bypass and a
// per-register pending-write scoreboard that produces the ID stall.
//   Clk   : clock, rising edge
//   Rst_n : asynchronous active-low reset
//   bus   : read ports, issue info, writeback lanes, flush in;
//           read data, stall, busy vector and sticky underflow error out
module decode_regfile_scoreboard
   import decode_pkg::*;
(
   input logic                        Clk,
   input logic                        Rst_n,
   decode_regfile_scoreboard_if.slave bus
);

   // r0 is hardwired to zero, so it has no storage and no counter.
   logic [DATA_W-1:0] regs_q [1:NREG-1];
   logic [CNT_W-1:0]  cnt    [NREG];
   logic [DEC_W-1:0]  dec    [NREG];
   logic [NREG-1:0]   sat, uflow, inc;
   logic [NRD-1:0]    src_rdy;
   logic              issue_fire;
   logic              err_q;

   always_comb begin
      for (int r = 0; r < NREG; r++) dec[r] = lane_match_cnt(bus.wb_en, bus.wb_addr, AW'(r));
   end

   // Later lanes overwrite earlier ones, so the highest-index lane wins.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int r = 1; r < NREG; r++) regs_q[r] <= '0;
      end else begin
         for (int l = 0; l < NWB; l++) begin
            if (bus.wb_en[l] && (wb_addr_at(bus.wb_addr, l) != '0))
               regs_q[wb_addr_at(bus.wb_addr, l)] <= wb_data_at(bus.wb_data, l);
         end
      end
   end

   // Read with bypass: scan lanes low to high so the highest match sticks.
   always_comb begin
      bus.rd_data = '0;
      for (int i = 0; i < NRD; i++) begin
         if (rd_addr_at(bus.rd_addr, i) != '0) begin
            bus.rd_data[i*DATA_W +: DATA_W] = regs_q[rd_addr_at(bus.rd_addr, i)];
            for (int l = 0; l < NWB; l++) begin
               if (bus.wb_en[l] && (wb_addr_at(bus.wb_addr, l) == rd_addr_at(bus.rd_addr, i)))
                  bus.rd_data[i*DATA_W +: DATA_W] = wb_data_at(bus.wb_data, l);
            end
         end
      end
   end

   // A source is ready once every pending write to it retires by this edge;
   // the last one is then visible through the bypass.
   always_comb begin
      src_rdy = '1;
      for (int i = 0; i < NRD; i++) begin
         if (bus.iss_src_en[i] && (rd_addr_at(bus.rd_addr, i) != '0) &&
             (int'(cnt[rd_addr_at(bus.rd_addr, i)]) != int'(dec[rd_addr_at(bus.rd_addr, i)])))
            src_rdy[i] = 1'b0;
      end
      bus.stall  = bus.iss_valid && (!(&src_rdy) || (bus.iss_dst_en && sat[bus.iss_dst]));
      issue_fire = bus.iss_valid && !bus.stall;
      for (int r = 0; r < NREG; r++) bus.busy[r] = (cnt[r] != '0);
   end

   assign cnt[0]   = '0;
   assign sat[0]   = 1'b0;
   assign uflow[0] = 1'b0;
   assign inc[0]   = 1'b0;

   for (genvar r = 1; r < NREG; r++) begin : g_cnt
      assign inc[r] = issue_fire && bus.iss_dst_en && (bus.iss_dst == AW'(r));
      sb_counter u_cnt (
         .clk_i       (Clk),
         .rst_ni      (Rst_n),
         .inc_i       (inc[r]),
         .dec_i       (dec[r]),
         .clr_i       (bus.flush),
         .cnt_o       (cnt[r]),
         .sat_o       (sat[r]),
         .underflow_o (uflow[r])
      );
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) err_q <= 1'b0;
      else        err_q <= err_q | (|uflow);
   end

   assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_decode_regfile_scoreboard.sv
module tb_decode_regfile_scoreboard;
   import decode_pkg::*;

   logic Clk   = 1'b0;
   logic Rst_n = 1'b0;
   always #5 Clk = ~Clk;

   decode_regfile_scoreboard_if bus();

   decode_regfile_scoreboard dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];

   // ---------------- driver tasks ----------------
   task automatic idle();
      bus.rd_addr    = '0;
      bus.iss_src_en = '0;
      bus.iss_valid  = 1'b0;
      bus.iss_dst_en = 1'b0;
      bus.iss_dst    = '0;
      bus.wb_en      = '0;
      bus.wb_addr    = '0;
      bus.wb_data    = '0;
      bus.flush      = 1'b0;
   endtask

   // Move to 1 time unit after the next rising edge and clear inputs.
   task automatic cycle();
      @(posedge Clk);
      #1;
      idle();
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic issue_dst(input logic [AW-1:0] dst);
      bus.iss_valid  = 1'b1;
      bus.iss_dst_en = 1'b1;
      bus.iss_dst    = dst;
   endtask

   task automatic set_src(input int i, input logic en, input logic [AW-1:0] a);
      bus.iss_src_en[i]       = en;
      bus.rd_addr[i*AW +: AW] = a;
   endtask

   task automatic set_wb(input int l, input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
      bus.wb_en[l]                    = 1'b1;
      bus.wb_addr[l*AW +: AW]         = a;
      bus.wb_data[l*DATA_W +: DATA_W] = d;
   endtask

   // ---------------- scoreboard ----------------
   task automatic expect_val(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL %s: observed %h, no expected value queued", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   function automatic logic [31:0] rd(input int i);
      return bus.rd_data[i*DATA_W +: DATA_W];
   endfunction

   // ---------------- directed sequence ----------------
   initial begin
      idle();
      repeat (2) @(posedge Clk);
      #1 Rst_n = 1'b1;
      set_src(0, 1'b0, 5'd5);
      settle();
      expect_val(32'h0); check("reset_rd0", rd(0));
      expect_val(32'h0); check("reset_busy", 32'(bus.busy));
      expect_val(32'h0); check("reset_stall", 32'(bus.stall));
      expect_val(32'h0); check("reset_err", 32'(bus.err_underflow));

      // Traffic on r5, including an underflow, then an asynchronous reset.
      cycle(); issue_dst(5'd5); settle();
      expect_val(32'h0); check("r5_issue_stall", 32'(bus.stall));
      cycle(); set_wb(0, 5'd5, 32'hA5A5_0005); set_src(0, 1'b0, 5'd5); settle();
      expect_val(32'hA5A5_0005); check("r5_bypass_lane0", rd(0));
      expect_val(32'h1); check("r5_busy", 32'(bus.busy[5]));
      cycle(); set_wb(1, 5'd5, 32'h1234_5678); set_src(1, 1'b0, 5'd5); settle();
      expect_val(32'h1234_5678); check("r5_bypass_lane1", rd(1));
      cycle(); set_src(0, 1'b0, 5'd5); settle();
      expect_val(32'h1); check("r5_underflow_err", 32'(bus.err_underflow));
      expect_val(32'h1234_5678); check("r5_array", rd(0));
      issue_dst(5'd5);
      cycle(); bus.iss_valid = 1'b1; set_src(0, 1'b1, 5'd5); settle();
      expect_val(32'h1); check("r5_busy_again", 32'(bus.busy[5]));
      expect_val(32'h1); check("r5_src_stall", 32'(bus.stall));
      #1 Rst_n = 1'b0;
      #1;
      expect_val(32'h0); check("midreset_rd0", rd(0));
      expect_val(32'h0); check("midreset_busy", 32'(bus.busy));
      expect_val(32'h0); check("midreset_stall", 32'(bus.stall));
      expect_val(32'h0); check("midreset_err", 32'(bus.err_underflow));
      @(posedge Clk);
      #1 Rst_n = 1'b1;

      // RAW hazard on r3 resolved by a same-cycle writeback.
      cycle(); issue_dst(5'd3); settle();
      expect_val(32'h0); check("r3_issue_stall", 32'(bus.stall));
      cycle(); bus.iss_valid = 1'b1; set_src(0, 1'b1, 5'd3); settle();
      expect_val(32'h1); check("r3_raw_stall", 32'(bus.stall));
      bus.iss_valid = 1'b0; #1;
      expect_val(32'h0); check("r3_novalid_stall", 32'(bus.stall));
      cycle(); bus.iss_valid = 1'b1; set_src(0, 1'b1, 5'd3); set_wb(0, 5'd3, 32'hDEAD_BEEF); settle();
      expect_val(32'h0); check("r3_wb_stall", 32'(bus.stall));
      expect_val(32'hDEAD_BEEF); check("r3_wb_bypass", rd(0));
      cycle(); settle();
      expect_val(32'h0); check("r3_busy_clear", 32'(bus.busy[3]));

      // Counter saturation on r7.
      for (int k = 0; k < 3; k++) begin
         cycle(); issue_dst(5'd7); settle();
         expect_val(32'h0); check("r7_fill_stall", 32'(bus.stall));
      end
      cycle(); issue_dst(5'd7); settle();
      expect_val(32'h1); check("r7_sat_stall", 32'(bus.stall));
      expect_val(32'h1); check("r7_busy", 32'(bus.busy[7]));
      cycle(); set_wb(0, 5'd7, 32'h77); settle();
      cycle(); issue_dst(5'd7); settle();
      expect_val(32'h0); check("r7_after_wb_stall", 32'(bus.stall));
      cycle(); set_wb(0, 5'd7, 32'h70); set_wb(1, 5'd7, 32'h71); settle();
      cycle(); set_wb(0, 5'd7, 32'h72); settle();
      cycle(); settle();
      expect_val(32'h0); check("r7_drained_busy", 32'(bus.busy));
      expect_val(32'h0); check("r7_drained_err", 32'(bus.err_underflow));

      // Two lanes retire r9 in one cycle; highest lane wins.
      cycle(); issue_dst(5'd9); settle();
      cycle(); issue_dst(5'd9); settle();
      cycle(); bus.iss_valid = 1'b1; set_src(0, 1'b1, 5'd9);
      set_wb(0, 5'd9, 32'h11); set_wb(1, 5'd9, 32'h22); settle();
      expect_val(32'h0); check("r9_dual_wb_stall", 32'(bus.stall));
      expect_val(32'h22); check("r9_dual_bypass", rd(0));
      cycle(); set_src(0, 1'b0, 5'd9); settle();
      expect_val(32'h22); check("r9_array", rd(0));
      expect_val(32'h0); check("r9_busy", 32'(bus.busy[9]));
      expect_val(32'h0); check("r9_err", 32'(bus.err_underflow));

      // Register 0 is never written, counted or stalled on.
      cycle(); set_wb(0, 5'd0, 32'hFFFF_FFFF); issue_dst(5'd0);
      set_src(0, 1'b1, 5'd0); set_src(1, 1'b1, 5'd0); settle();
      expect_val(32'h0); check("r0_rd0", rd(0));
      expect_val(32'h0); check("r0_rd1", rd(1));
      expect_val(32'h0); check("r0_stall", 32'(bus.stall));
      cycle(); settle();
      expect_val(32'h0); check("r0_busy", 32'(bus.busy));
      expect_val(32'h0); check("r0_array", rd(0));
      expect_val(32'h0); check("r0_err", 32'(bus.err_underflow));

      // Flush with a same-cycle issue, then an orphan writeback.
      cycle(); issue_dst(5'd4); settle();
      cycle(); bus.flush = 1'b1; issue_dst(5'd4); settle();
      expect_val(32'h0); check("r4_flush_stall", 32'(bus.stall));
      expect_val(32'h1); check("r4_busy_pre_flush", 32'(bus.busy[4]));
      cycle(); settle();
      expect_val(32'h0); check("r4_busy_post_flush", 32'(bus.busy));
      cycle(); bus.flush = 1'b1; set_wb(0, 5'd6, 32'h66); settle();
      cycle(); set_src(0, 1'b0, 5'd6); settle();
      expect_val(32'h66); check("r6_flush_wb_array", rd(0));
      expect_val(32'h0); check("r6_flush_wb_err", 32'(bus.err_underflow));
      cycle(); set_wb(0, 5'd4, 32'h44); settle();
      cycle(); settle();
      expect_val(32'h1); check("r4_underflow_err", 32'(bus.err_underflow));
      cycle(); settle();
      expect_val(32'h1); check("r4_err_sticky", 32'(bus.err_underflow));

      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_regfile_scoreboard.md
Name: decode_regfile_scoreboard

Overview:
- Parametrised successor to the decode-stage register file and bypass logic.
- Holds an NREG x DATA_W register file with NRD combinational read ports and NWB writeback lanes, and forwards same-cycle writeback data to the read ports.
- Adds a per-register pending-write scoreboard: it counts in-flight destination writes and generates the decode stall.
- Sits in the ID stage. Replaces fixed-depth hazard compares against the EX/MEM/SAD write-register ports with a counter-based, depth-independent scheme.

Parameters:
- DATA_W, 32, register width.
- NREG, 32, number of architectural registers; register 0 is hardwired to zero.
- AW, $clog2(NREG), register address width.
- NRD, 2, number of read/source ports.
- NWB, 2, number of writeback lanes.
- CNT_W, 2, pending-counter width; at most 2^CNT_W-1 outstanding writes per register.

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous reset, active-low.
- rd_addr  in  NRD*AW  source register addresses; port i is at slice i.
- rd_data  out  NRD*DATA_W  bypassed read data.
- iss_src_en  in  NRD  source i is used by the issuing instruction.
- iss_valid  in  1  decoded instruction presented for issue.
- iss_dst_en  in  1  issuing instruction writes a register.
- iss_dst  in  AW  destination register.
- wb_en  in  NWB  writeback lane valid.
- wb_addr  in  NWB*AW  writeback destination.
- wb_data  in  NWB*DATA_W  writeback data.
- flush  in  1  squash all in-flight writes from the scoreboard.
- stall  out  1  hold the ID stage this cycle.
- busy  out  NREG  bit r is 1 when cnt[r] != 0.
- err_underflow  out  1  sticky: a writeback retired a register with no pending write.

Behaviour:
- Reset (Rst_n low, asynchronous):
  - all array entries and counters go to 0; err_underflow goes to 0.
  - rd_data reads 0; busy = 0; stall = 0.
  - Reset mid-operation discards all pending state immediately.
- Register 0:
  - reads return 0;
  - writes to it are ignored;
  - it is never counted as pending and never causes a stall.
- Write (at the Clk edge): every wb_en lane with addr != 0 writes the array. If several lanes target the same address, the highest-index lane wins.
- Read (combinational, zero latency):
  - rd_data[i] takes wb_data of the highest-index enabled lane whose addr matches rd_addr[i] (addr != 0);
  - otherwise it takes the array value.
- Scoreboard counters cnt[r], per cycle:
  - inc = 1 when issue_fire & iss_dst_en & iss_dst == r & r != 0, where issue_fire = iss_valid & !stall.
  - dec = number of enabled wb lanes with addr == r.
  - next value is cnt + inc - dec; inc and dec in the same cycle net out.
  - If dec exceeds cnt + inc, the counter clamps to 0 and err_underflow sets; it clears only on reset.
- Source readiness: source i is ready when iss_src_en[i] == 0, or rd_addr[i] == 0, or cnt[rd_addr[i]] == dec(rd_addr[i]). In the last case the final pending write lands this cycle and is bypassed.
- stall = iss_valid & (any source not ready, or (iss_dst_en & iss_dst != 0 & cnt[iss_dst] == 2^CNT_W-1)).
  - stall is combinational from registered counters and the current inputs.
  - stall is 0 whenever iss_valid = 0.
- flush:
  - all counters go to 0 at the next edge;
  - any issue in the same cycle is not counted;
  - writebacks in the same cycle still update the array and do not set err_underflow.
- busy is derived combinationally from the counters; it does not include the current-cycle issue.

Decomposition:
- Shared package decode_pkg: DATA_W/NREG/NRD/NWB/CNT_W defaults; functions for slice extraction and a lane-match popcount.
- One natural sub-module, sb_counter: a single-register pending counter with inc, dec-count and clear inputs, producing cnt, sat and underflow; generate it NREG-1 times.
- The array and bypass mux stay in the top level.

Test Plan:
- Reset with Rst_n=0 mid-traffic, then read r5 -> rd_data=0, busy=0, stall=0, err_underflow=0.
- Issue dst r3; next cycle issue src r3 with no wb -> stall=1. Same cycle as wb lane0 r3=0xDEADBEEF -> stall=0 and rd_data=0xDEADBEEF.
- Issue dst r7 three times (CNT_W=2), then a fourth issue to r7 -> stall=1; one wb to r7 -> cnt=2 and the next issue proceeds.
- Both lanes write r9 in the same cycle (0x11, 0x22) with cnt[r9]=2 -> array r9=0x22, bypass gives 0x22, cnt[r9]=0.
- Write r0=0xFFFF_FFFF and issue dst r0 -> reads of r0 return 0, busy[0]=0, no stall.
- cnt[r4]=1 with flush plus issue dst r4 in the same cycle -> cnt[r4]=0. A later wb to r4 -> err_underflow=1 and stays 1.
